cordic_frontend: RTL

Range-reduction and input-handshake stage placed directly upstream of the CORDIC `pipeline`. It accepts requests over a valid/ready handshake. For rotation it wraps an arbitrary Q7.8 radian angle into [-π, π], folds it into [0, π/2], and produces the matching 2-bit sector flag. For arctan it maps the vector into the right half-plane. A tag delay line tracks each issued request through the fixed-latency pipeline, so consumers know when `pipeline` outputs are meaningful.

---
 rtl/cordic_frontend_if.sv | 40 ++++
 rtl/cordic_frontend.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/cordic_frontend_if.sv
// ---------------------------------------------------------------------------
// cordic_frontend_if
// Request/response bundle between an upstream requester and cordic_frontend.
//   Request side : in_valid, in_ready, angle_in, x_in, y_in, arctan_en_in
//   Pipeline side: degree_out, x_out, y_out, sector_out, arctan_en_out,
//                  out_valid, result_valid
// Modports:
//   master - requester / consumer view (drives the request fields)
//   slave  - frontend view (drives in_ready and all pipeline-side outputs)
// ---------------------------------------------------------------------------
interface cordic_frontend_if #(
  parameter int DATA_WIDTH        = 16,
  parameter int SECTOR_FLAG_WIDTH = 2
);
  logic                                in_valid;
  logic                                in_ready;
  logic signed [DATA_WIDTH-1:0]        angle_in;
  logic signed [DATA_WIDTH-1:0]        x_in;
  logic signed [DATA_WIDTH-1:0]        y_in;
  logic                                arctan_en_in;
  logic signed [DATA_WIDTH-1:0]        degree_out;
  logic signed [DATA_WIDTH-1:0]        x_out;
  logic signed [DATA_WIDTH-1:0]        y_out;
  logic        [SECTOR_FLAG_WIDTH-1:0] sector_out;
  logic                                arctan_en_out;
  logic                                out_valid;
  logic                                result_valid;

  modport master (
    output in_valid, angle_in, x_in, y_in, arctan_en_in,
    input  in_ready, degree_out, x_out, y_out, sector_out, arctan_en_out,
           out_valid, result_valid
  );

  modport slave (
    input  in_valid, angle_in, x_in, y_in, arctan_en_in,
    output in_ready, degree_out, x_out, y_out, sector_out, arctan_en_out,
           out_valid, result_valid
  );
endinterface

// File: rtl/cordic_frontend.sv
// ---------------------------------------------------------------------------
// cordic_frontend
// Range reduction and input handshake ahead of the CORDIC pipeline.
//   Rotation: wraps a Q7.8 radian angle into [-pi, pi], folds it into
//             [0, pi/2] and emits the matching 2-bit sector flag.
//   Arctan  : mirrors the vector into the right half-plane (sector 2 when
//             mirrored, 0 otherwise), degree forced to 0.
//   A tag delay line of PIPE_LATENCY bits marks when pipeline results are
//   valid.
// Ports:
//   clk   - clock
//   reset - asynchronous, active-low reset
//   bus   - cordic_frontend_if.slave (request handshake + pipeline drive)
// Build option:
//   CORDIC_FRONTEND_WRAP_EN defined   : iterative WRAP state reduces any angle
//   CORDIC_FRONTEND_WRAP_EN undefined : angles saturate to +/-pi at capture,
//                                       latency is always one cycle
// ---------------------------------------------------------------------------
module cordic_frontend #(
  parameter int                            DATA_WIDTH        = 16,
  parameter int                            SECTOR_FLAG_WIDTH = 2,
  parameter int                            PIPE_LATENCY      = 9,
  parameter logic signed [DATA_WIDTH-1:0]  PI_Q              = 16'sh0324,
  parameter logic signed [DATA_WIDTH-1:0]  HALF_PI_Q         = 16'sh0192,
  parameter logic signed [DATA_WIDTH-1:0]  TWO_PI_Q          = 16'sh0648
) (
  input logic              clk,
  input logic              reset,
  cordic_frontend_if.slave bus
);

  // One extra bit so a wrap step on a full-scale angle cannot overflow.
  localparam int AW = DATA_WIDTH + 1;

  localparam logic signed [AW-1:0]         PI_A      = AW'(PI_Q);
  localparam logic signed [AW-1:0]         HALF_PI_A = AW'(HALF_PI_Q);
  localparam logic signed [AW-1:0]         TWO_PI_A  = AW'(TWO_PI_Q);
  localparam logic signed [DATA_WIDTH-1:0] MIN_D     = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [DATA_WIDTH-1:0] MAX_D     = {1'b0, {(DATA_WIDTH-1){1'b1}}};

`ifdef CORDIC_FRONTEND_WRAP_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WRAP = 2'd1, ST_FOLD = 2'd2} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_FOLD = 2'd2} state_t;
`endif

  // Two's-complement negate; the most negative code has no positive twin.
  function automatic logic signed [DATA_WIDTH-1:0] neg_sat(
    input logic signed [DATA_WIDTH-1:0] v);
    if (v == MIN_D) neg_sat = MAX_D;
    else            neg_sat = -v;
  endfunction

  function automatic logic signed [AW-1:0] clamp_pi(input logic signed [AW-1:0] v);
    if (v > PI_A)       clamp_pi = PI_A;
    else if (v < -PI_A) clamp_pi = -PI_A;
    else                clamp_pi = v;
  endfunction

  function automatic logic signed [AW-1:0] wrap_step(input logic signed [AW-1:0] v);
    if (v > PI_A)       wrap_step = v - TWO_PI_A;
    else if (v < -PI_A) wrap_step = v + TWO_PI_A;
    else                wrap_step = v;
  endfunction

  function automatic logic in_range(input logic signed [AW-1:0] v);
    in_range = (v >= -PI_A) && (v <= PI_A);
  endfunction

  state_t                         state_q, state_d;
  logic signed [AW-1:0]           a_q, a_d;
  logic signed [DATA_WIDTH-1:0]   x_q, x_d;
  logic signed [DATA_WIDTH-1:0]   y_q, y_d;
  logic                           mode_q, mode_d;
  logic signed [DATA_WIDTH-1:0]   deg_q, deg_d;
  logic signed [DATA_WIDTH-1:0]   xo_q, xo_d;
  logic signed [DATA_WIDTH-1:0]   yo_q, yo_d;
  logic [SECTOR_FLAG_WIDTH-1:0]   sec_q, sec_d;
  logic                           aten_q, aten_d;
  logic                           ov_q, ov_d;
  logic [PIPE_LATENCY-1:0]        tag_q;

  logic signed [AW-1:0]           angle_ext;
  logic signed [DATA_WIDTH-1:0]   fold_deg;
  logic [SECTOR_FLAG_WIDTH-1:0]   fold_sec;

  assign angle_ext = AW'(bus.angle_in);

  // Quadrant fold of a reduced angle in [-pi, pi]; result fits DATA_WIDTH.
  always_comb begin
    fold_deg = DATA_WIDTH'(a_q);
    fold_sec = '0;
    if (a_q > HALF_PI_A) begin
      fold_deg = DATA_WIDTH'(PI_A - a_q);
      fold_sec = SECTOR_FLAG_WIDTH'(1);
    end else if (!a_q[AW-1]) begin
      fold_deg = DATA_WIDTH'(a_q);
      fold_sec = SECTOR_FLAG_WIDTH'(0);
    end else if (a_q >= -HALF_PI_A) begin
      fold_deg = DATA_WIDTH'(-a_q);
      fold_sec = SECTOR_FLAG_WIDTH'(3);
    end else begin
      fold_deg = DATA_WIDTH'(a_q + PI_A);
      fold_sec = SECTOR_FLAG_WIDTH'(2);
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    x_d     = x_q;
    y_d     = y_q;
    mode_d  = mode_q;
    deg_d   = deg_q;
    xo_d    = xo_q;
    yo_d    = yo_q;
    sec_d   = sec_q;
    aten_d  = aten_q;
    ov_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          x_d    = bus.x_in;
          y_d    = bus.y_in;
          mode_d = bus.arctan_en_in;
          if (bus.arctan_en_in) begin
            a_d     = '0;
            state_d = ST_FOLD;
          end else begin
`ifdef CORDIC_FRONTEND_WRAP_EN
            a_d     = angle_ext;
            state_d = in_range(angle_ext) ? ST_FOLD : ST_WRAP;
`else
            a_d     = clamp_pi(angle_ext);
            state_d = ST_FOLD;
`endif
          end
        end
      end
`ifdef CORDIC_FRONTEND_WRAP_EN
      // Leave as soon as the freshly stepped value is in range, so N steps
      // cost exactly N cycles here.
      ST_WRAP: begin
        a_d = wrap_step(a_q);
        if (in_range(a_d)) state_d = ST_FOLD;
      end
`endif
      ST_FOLD: begin
        aten_d  = mode_q;
        ov_d    = 1'b1;
        state_d = ST_IDLE;
        if (mode_q) begin
          deg_d = '0;
          if (x_q[DATA_WIDTH-1]) begin
            xo_d  = neg_sat(x_q);
            yo_d  = neg_sat(y_q);
            sec_d = SECTOR_FLAG_WIDTH'(2);
          end else begin
            xo_d  = x_q;
            yo_d  = y_q;
            sec_d = SECTOR_FLAG_WIDTH'(0);
          end
        end else begin
          deg_d = fold_deg;
          xo_d  = x_q;
          yo_d  = y_q;
          sec_d = fold_sec;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Capture / reduction / output register stage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      mode_q  <= 1'b0;
      deg_q   <= '0;
      xo_q    <= '0;
      yo_q    <= '0;
      sec_q   <= '0;
      aten_q  <= 1'b0;
      ov_q    <= 1'b0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      x_q     <= x_d;
      y_q     <= y_d;
      mode_q  <= mode_d;
      deg_q   <= deg_d;
      xo_q    <= xo_d;
      yo_q    <= yo_d;
      sec_q   <= sec_d;
      aten_q  <= aten_d;
      ov_q    <= ov_d;
      tag_q   <= {tag_q[PIPE_LATENCY-2:0], ov_q};
    end
  end

  assign bus.in_ready      = (state_q == ST_IDLE);
  assign bus.degree_out    = deg_q;
  assign bus.x_out         = xo_q;
  assign bus.y_out         = yo_q;
  assign bus.sector_out    = sec_q;
  assign bus.arctan_en_out = aten_q;
  assign bus.out_valid     = ov_q;
  assign bus.result_valid  = tag_q[PIPE_LATENCY-1];

endmodule
